framebuffer_scanout: RTL and testbench
======================================

# framebuffer_scanout

Display-side reader for the 1-bit-per-pixel framebuffer in `memory`, which `addr_to_pixel_writer` fills. The block runs in the 35 MHz domain and generates 800x600 VGA timing. For each visible pixel it fetches the framebuffer word through a dedicated second read port and drives 4:4:4 RGB with hsync and vsync. Pixels that are set are drawn in the foreground colour; all other pixels are drawn in the background colour.

## Interface
Parameters:
- `H_VISIBLE`, 800, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 24 / 72 / 128, horizontal porch and sync widths (line total 1024)
- `V_VISIBLE`, 600, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 1 / 2 / 22, vertical porch and sync widths (frame total 625)
- `WORDS_PER_LINE`, 25, equals `H_VISIBLE`/32
- `ADDRESS_LENGTH`, 14, framebuffer word-address width
- `DATA_WIDTH`, 32, framebuffer word width
- `FG_COLOR`, 12'hFFF, {R,G,B} colour for a set pixel
- `BG_COLOR`, 12'h000, {R,G,B} colour for a clear pixel
- `SYNC_ACTIVE`, 1'b1, active level of hsync and vsync

Ports:
- `clk`  in  1  35 MHz pixel clock
- `reset`  in  1  asynchronous, active-high
- `rd_addr`  out  ADDRESS_LENGTH  framebuffer read word address
- `rd_en`  out  1  read strobe, high while `rd_addr` is meaningful
- `rd_data`  in  DATA_WIDTH  framebuffer word, registered in memory, 1-cycle latency from `rd_addr`
- `vga_r`, `vga_g`, `vga_b`  out  4 each  pixel colour
- `hsync`, `vsync`  out  1 each  sync outputs
- `frame_start`  out  1  one-cycle pulse coincident with output pixel (0,0)

## Operation
- Stage 0 holds the counters. `h` counts 0..1023 and wraps to 0. `v` increments when `h` wraps, counts 0..624, then wraps to 0.
- Pixel mapping: pixel (x,y) lives in word `y*25 + x[9:5]` at bit `x[4:0]`, LSB first. This matches the translator's word_address/bit_offset convention.
- The line base register replaces the multiplier:
  - Reset value is 0.
  - At `h`=1023, `line_base` += 25 when `v` < 599.
  - At `h`=1023 with `v`=624, `line_base` is cleared to 0.
  - During lines 599..624 it holds 14975.
- Stage 1 (registered), driven from the stage-0 `h`/`v`:
  - When `h` < 800 and `v` < 600: `rd_addr` <= `line_base + h[9:5]` and `rd_en` <= 1.
  - Otherwise: `rd_addr` <= 0 and `rd_en` <= 0.
  - Stage 1 also registers `x[4:0]`, the active flag, and the raw syncs.
- Stage 2: `rd_data` returns from memory. The `x[4:0]`, active, sync and first-pixel flags advance one register.
- Stage 3 (output registers):
  - When active: colour = `FG_COLOR` if `rd_data[x[4:0]]`, else `BG_COLOR`.
  - When inactive: colour = 0 regardless of `rd_data`.
- Sync windows at the counter stage:
  - hsync is active for `h` in [824, 896).
  - vsync is active for `v` in [601, 603), across full lines.
  - Both are delayed 3 stages.
- `frame_start` is the counter-stage (h=0, v=0) flag delayed 3 stages.
- The maximum address issued is 14999. Addresses 15000..16383 are never read.

## Timing
- Latency is 3 clocks from counter value to output pins. Colour, syncs and `frame_start` share the same 3-stage pipe and stay mutually aligned.
- Reset values (all asynchronous):
  - `h`, `v`, `line_base` = 0.
  - `rd_addr` = 0, `rd_en` = 0.
  - All pipeline active, first-pixel and sync flags cleared.
  - `vga_*` = 0, `frame_start` = 0.
  - `hsync`, `vsync` = `~SYNC_ACTIVE`.
- After reset deasserts, pixel (0,0) appears on the outputs following the 3rd rising edge, with `frame_start` = 1 in that cycle. The two preceding cycles output blank with syncs inactive.
- Line period is 1024 clocks; frame period is 640000 clocks (about 54.7 Hz at 35 MHz). Monitor-tolerated 800x600@56 timing.
- Reset mid-frame: outputs go to reset values immediately. On release, the block restarts at (0,0) with no partial-word carry-over.
- The read port is used every visible cycle; there is no backpressure or handshake. A word is re-read for each of its 32 pixels, which is intentional because it keeps the pipeline stateless.
- Writer and scanout accesses to the same word in the same cycle are legal. Scanout may show the pre-write value for one frame.

## Test plan
- Hold reset mid-line, then release. Required: all outputs at reset values during reset; `frame_start` and pixel (0,0) after exactly 3 rising edges.
- Memory model returns `rd_data` = 32'h00000001 only for address 0, zero elsewhere. Required: exactly one `FG_COLOR` pixel per frame, at output cycle 0 (the `frame_start` cycle). All other visible pixels are `BG_COLOR`.
- Count over two frames. Required:
  - hsync active for 72 clocks every 1024, rising 824 clocks after the line start.
  - vsync active for 2048 clocks every 640000.
  - `rd_en` high for exactly 480000 clocks per frame.
- Monitor `rd_addr`. Required:
  - Address 24 is issued at (x=768, y=0).
  - Address 25 at (0,1).
  - Address 14999 at (799,599).
  - The address returns to 0 at the next (0,0).
  - No address exceeds 14999.
- Memory model returns all-ones. Required: every blanking-interval output is 0; every visible output is `FG_COLOR`.
- Memory model returns `rd_data` = 32'h80000000 at address 0. Required: the pixel at x=31, y=0 is `FG_COLOR`; pixels x=0..30 on that line are `BG_COLOR`.

Source files
------------

// File: rtl/framebuffer_scanout_if.sv
// Framebuffer second read port: scanout drives address/strobe, memory returns the
// registered word one clock later.
interface framebuffer_scanout_if #(
  parameter int ADDRESS_LENGTH = 14,
  parameter int DATA_WIDTH     = 32
);
  logic [ADDRESS_LENGTH-1:0] rd_addr;
  logic                      rd_en;
  logic [DATA_WIDTH-1:0]     rd_data;

  modport master (output rd_addr, rd_en, input rd_data);
  modport slave  (input rd_addr, rd_en, output rd_data);
endinterface

// File: rtl/framebuffer_scanout.sv
// 1bpp framebuffer scanout: VGA timing counters, one word fetch per visible pixel,
// and a 3-stage pipe keeping colour, syncs and frame_start aligned.
module framebuffer_scanout #(
  parameter int          H_VISIBLE      = 800,
  parameter int          H_FP           = 24,
  parameter int          H_SYNC         = 72,
  parameter int          H_BP           = 128,
  parameter int          V_VISIBLE      = 600,
  parameter int          V_FP           = 1,
  parameter int          V_SYNC         = 2,
  parameter int          V_BP           = 22,
  parameter int          WORDS_PER_LINE = 25,
  parameter int          ADDRESS_LENGTH = 14,
  parameter int          DATA_WIDTH     = 32,
  parameter logic [11:0] FG_COLOR       = 12'hFFF,
  parameter logic [11:0] BG_COLOR       = 12'h000,
  parameter logic        SYNC_ACTIVE    = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  framebuffer_scanout_if.master  rd,
  output logic [3:0]             vga_r,
  output logic [3:0]             vga_g,
  output logic [3:0]             vga_b,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(DATA_WIDTH);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_VLST = VW'(V_VISIBLE - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [ADDRESS_LENGTH-1:0] WPL = ADDRESS_LENGTH'(WORDS_PER_LINE);

  // stage 0: counters and the running line base (y*WORDS_PER_LINE without a multiplier)
  logic [HW-1:0]             h;
  logic [VW-1:0]             v;
  logic [ADDRESS_LENGTH-1:0] line_base;

  logic                      act0, hs0, vs0, first0;
  logic [XW-1:0]             x0;
  logic [ADDRESS_LENGTH-1:0] word0;

  assign act0   = (h < H_VIS) && (v < V_VIS);
  assign hs0    = (h >= HS_BEG) && (h < HS_END);
  assign vs0    = (v >= VS_BEG) && (v < VS_END);
  assign first0 = (h == '0) && (v == '0);
  assign x0     = h[XW-1:0];
  assign word0  = ADDRESS_LENGTH'(h >> XW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h         <= '0;
      v         <= '0;
      line_base <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      if (v == V_LAST) begin
        v         <= '0;
        line_base <= '0;
      end else begin
        v <= v + 1'b1;
        if (v < V_VLST) line_base <= line_base + WPL;
      end
    end else begin
      h <= h + 1'b1;
    end
  end

  // stages 1..2: fetch issue plus flag pipe; index 1 lines up with rd_addr, 2 with rd_data
  logic [2:1]         act_pipe, hs_pipe, vs_pipe, first_pipe;
  logic [2:1][XW-1:0] x_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd.rd_addr <= '0;
      rd.rd_en   <= 1'b0;
      act_pipe   <= '0;
      hs_pipe    <= '0;
      vs_pipe    <= '0;
      first_pipe <= '0;
      x_pipe     <= '0;
    end else begin
      rd.rd_en   <= act0;
      rd.rd_addr <= act0 ? (line_base + word0) : '0;
      act_pipe   <= {act_pipe[1], act0};
      hs_pipe    <= {hs_pipe[1], hs0};
      vs_pipe    <= {vs_pipe[1], vs0};
      first_pipe <= {first_pipe[1], first0};
      x_pipe     <= {x_pipe[1], x0};
    end
  end

  // stage 3: output registers; blanking forces black whatever memory returned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      hsync                 <= ~SYNC_ACTIVE;
      vsync                 <= ~SYNC_ACTIVE;
      frame_start           <= 1'b0;
    end else begin
      if (act_pipe[2])
        {vga_r, vga_g, vga_b} <= rd.rd_data[x_pipe[2]] ? FG_COLOR : BG_COLOR;
      else
        {vga_r, vga_g, vga_b} <= 12'h000;
      hsync       <= hs_pipe[2] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= vs_pipe[2] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_start <= first_pipe[2];
    end
  end
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench: full 800x600 instance checked against a vector table over the first
// lines, plus a shrunken-timing instance whose whole frames are counted.
module tb_framebuffer_scanout;
  // shrunken timing: 128-clock lines, 12-line frames, 64 visible pixels (2 words)
  localparam int S_HV = 64, S_HFP = 8, S_HS = 16, S_HBP = 40;
  localparam int S_VV = 6, S_VFP = 1, S_VS = 2, S_VBP = 3;
  localparam int S_HT = 128, S_VT = 12, S_FRAME = S_HT * S_VT;
  localparam logic [11:0] S_FG = 12'hF80, S_BG = 12'h035;
  localparam logic S_SA = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   mode = 0;
  int   cyc;
  int   n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  framebuffer_scanout_if #(.ADDRESS_LENGTH(14), .DATA_WIDTH(32)) fif ();
  framebuffer_scanout_if #(.ADDRESS_LENGTH(14), .DATA_WIDTH(32)) sif ();

  logic [3:0] f_r, f_g, f_b, s_r, s_g, s_b;
  logic f_hs, f_vs, f_fs, s_hs, s_vs, s_fs;

  framebuffer_scanout dut_full (
    .clk(clk), .reset(reset), .rd(fif.master),
    .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
    .hsync(f_hs), .vsync(f_vs), .frame_start(f_fs)
  );

  framebuffer_scanout #(
    .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .WORDS_PER_LINE(2), .ADDRESS_LENGTH(14), .DATA_WIDTH(32),
    .FG_COLOR(S_FG), .BG_COLOR(S_BG), .SYNC_ACTIVE(S_SA)
  ) dut_small (
    .clk(clk), .reset(reset), .rd(sif.master),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs)
  );

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    case (mode)
      0:       return (a == 14'd0) ? 32'h0000_0001 : 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return (a == 14'd0) ? 32'h8000_0000 : 32'h0;
    endcase
  endfunction

  // memory with registered read, one clock after rd_addr
  always @(posedge clk) begin
    fif.rd_data <= mem_word(fif.rd_addr);
    sif.rd_data <= mem_word(sif.rd_addr);
  end

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  // small-instance monitor: output pixel index p = cyc-3, fetch index q = cyc-1
  int hs_cnt, hs_err, vs_cnt, vs_err, en_cnt, max_addr, fg_cnt, bg_cnt, blank_err;
  int fs_cnt, fs_err, first_fg, bg_before;
  logic [14:0] addr_last, addr_wrap;

  always @(negedge clk) begin
    int p, q, hh, vv;
    logic vis, hsa, vsa;
    logic [11:0] rgb;
    if (reset) begin
      hs_cnt = 0; hs_err = 0; vs_cnt = 0; vs_err = 0; en_cnt = 0; max_addr = 0;
      fg_cnt = 0; bg_cnt = 0; blank_err = 0; fs_cnt = 0; fs_err = 0;
      first_fg = -1; bg_before = 0; addr_last = '1; addr_wrap = '1;
    end else begin
      p = cyc - 3;
      if (p >= 0 && p < 2 * S_FRAME) begin
        hh  = p % S_HT;
        vv  = (p / S_HT) % S_VT;
        vis = (hh < S_HV) && (vv < S_VV);
        rgb = {s_r, s_g, s_b};
        hsa = (s_hs == S_SA);
        vsa = (s_vs == S_SA);
        if (hsa) hs_cnt++;
        if (hsa != (hh >= S_HV + S_HFP && hh < S_HV + S_HFP + S_HS)) hs_err++;
        if (vsa) vs_cnt++;
        if (vsa != (vv >= S_VV + S_VFP && vv < S_VV + S_VFP + S_VS)) vs_err++;
        if (s_fs) fs_cnt++;
        if (s_fs && (p % S_FRAME) != 0) fs_err++;
        if (!vis && rgb != 12'h000) blank_err++;
        if (vis && rgb == S_FG) begin
          fg_cnt++;
          if (first_fg < 0) first_fg = p;
        end
        if (vis && rgb == S_BG) begin
          bg_cnt++;
          if (first_fg < 0) bg_before++;
        end
      end
      q = cyc - 1;
      if (q >= 0 && q < 2 * S_FRAME) begin
        if (sif.rd_en) begin
          en_cnt++;
          if (int'(sif.rd_addr) > max_addr) max_addr = int'(sif.rd_addr);
        end
        if (q == (S_VV - 1) * S_HT + S_HV - 1) addr_last = {sif.rd_en, sif.rd_addr};
        if (q == S_FRAME)                      addr_wrap = {sif.rd_en, sif.rd_addr};
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (cyc < n) check("wait_timeout", 64'(cyc), 64'(n));
  endtask

  task automatic restart(input int m);
    @(negedge clk);
    reset = 1'b1;
    mode  = m;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int          cyc;
    logic        en;
    logic [13:0] addr;
    logic [11:0] rgb;
    logic        hs, vs, fs;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // {edges after release, rd_en, rd_addr, rgb, hsync, vsync, frame_start} for dut_full, mode 0
    vecs[0]  = '{1,    1'b1, 14'd0,  12'h000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2,    1'b1, 14'd0,  12'h000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3,    1'b1, 14'd0,  12'hFFF, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{4,    1'b1, 14'd0,  12'h000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{33,   1'b1, 14'd1,  12'h000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{769,  1'b1, 14'd24, 12'h000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{800,  1'b1, 14'd24, 12'h000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{801,  1'b0, 14'd0,  12'h000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{826,  1'b0, 14'd0,  12'h000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{827,  1'b0, 14'd0,  12'h000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{898,  1'b0, 14'd0,  12'h000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{899,  1'b0, 14'd0,  12'h000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1025, 1'b1, 14'd25, 12'h000, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1027, 1'b1, 14'd25, 12'h000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1824, 1'b1, 14'd49, 12'h000, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1825, 1'b0, 14'd0,  12'h000, 1'b0, 1'b0, 1'b0};

    // power-on reset values
    repeat (2) @(negedge clk);
    check("por_full", {fif.rd_en, fif.rd_addr, f_r, f_g, f_b, f_hs, f_vs, f_fs}, 64'h0);
    check("por_small", {sif.rd_en, sif.rd_addr, s_r, s_g, s_b, s_hs, s_vs, s_fs},
          {1'b0, 14'd0, 12'h000, 1'b1, 1'b1, 1'b0});

    // run into the hsync window, then reset mid-line: outputs drop at once
    reset = 1'b0;
    wait_cyc(850);
    check("midline_hsync_active", {f_hs, f_r, f_g, f_b}, {1'b1, 12'h000});
    reset = 1'b1;
    #1;
    check("midline_reset_full", {fif.rd_en, fif.rd_addr, f_r, f_g, f_b, f_hs, f_vs, f_fs}, 64'h0);
    check("midline_reset_small", {s_r, s_g, s_b, s_hs, s_vs, s_fs},
          {12'h000, 1'b1, 1'b1, 1'b0});

    // mode 0: single set pixel at (0,0)
    restart(0);
    foreach (vecs[i]) begin
      wait_cyc(vecs[i].cyc);
      check($sformatf("vec%0d_cyc%0d", i, vecs[i].cyc),
            {fif.rd_en, fif.rd_addr, f_r, f_g, f_b, f_hs, f_vs, f_fs},
            {vecs[i].en, vecs[i].addr, vecs[i].rgb, vecs[i].hs, vecs[i].vs, vecs[i].fs});
    end
    wait_cyc(2 * S_FRAME + 4);
    check("m0_hsync_count",  64'(hs_cnt), 64'd384);
    check("m0_hsync_window", 64'(hs_err), 64'd0);
    check("m0_vsync_count",  64'(vs_cnt), 64'd512);
    check("m0_vsync_window", 64'(vs_err), 64'd0);
    check("m0_rd_en_count",  64'(en_cnt), 64'd768);
    check("m0_max_addr",     64'(max_addr), 64'd11);
    check("m0_addr_last",    64'(addr_last), {1'b1, 14'd11});
    check("m0_addr_wrap",    64'(addr_wrap), {1'b1, 14'd0});
    check("m0_fg_count",     64'(fg_cnt), 64'd2);
    check("m0_first_fg",     64'(first_fg), 64'd0);
    check("m0_bg_count",     64'(bg_cnt), 64'd766);
    check("m0_blank_zero",   64'(blank_err), 64'd0);
    check("m0_fs_count",     64'(fs_cnt), 64'd2);
    check("m0_fs_position",  64'(fs_err), 64'd0);

    // mode 1: all ones
    restart(1);
    wait_cyc(2 * S_FRAME + 4);
    check("m1_fg_count",   64'(fg_cnt), 64'd768);
    check("m1_bg_count",   64'(bg_cnt), 64'd0);
    check("m1_blank_zero", 64'(blank_err), 64'd0);

    // mode 2: only bit 31 of word 0 set
    restart(2);
    wait_cyc(2 * S_FRAME + 4);
    check("m2_first_fg",  64'(first_fg), 64'd31);
    check("m2_bg_before", 64'(bg_before), 64'd31);
    check("m2_fg_count",  64'(fg_cnt), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
